// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared widths and loader state encoding
package prog_loader_pkg;

    localparam int PL_AW    = 4;
    localparam int PL_DW    = 8;
    localparam int PL_DEPTH = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_DATA = 3'd2,
        ST_FILL = 3'd3,
        ST_CSUM = 3'd4,
        ST_RUN  = 3'd5,
        ST_ERR  = 3'd6
    } state_t;

endpackage

// File: rtl/prog_mem.sv
// rtl/prog_mem.sv - program memory, sync write, async read, sync clear-all
module prog_mem #(
    parameter int AW    = 4,
    parameter int DW    = 8,
    parameter int DEPTH = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] r_mem [DEPTH];

    // Reset wipes every entry so no program survives a reset; otherwise one write per cycle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (we_i) begin
            r_mem[waddr_i] <= wdata_i;
        end
    end

    // CPU decodes in the same cycle it drives the address, so the read is combinational
    assign rdata_o = r_mem[raddr_i];

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - byte-stream program loader gating the CPU reset
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int AW    = PL_AW,
    parameter int DW    = PL_DW,
    parameter int DEPTH = PL_DEPTH
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [AW-1:0] p_addr_i,
    output logic [DW-1:0] p_data_o,
    output logic          cpu_rst_o,
    input  logic          ld_start_i,
    input  logic [7:0]    ld_data_i,
    input  logic          ld_valid_i,
    output logic          ld_ready_o,
    output logic          busy_o,
    output logic          err_o
);

    localparam logic [AW:0]   LEN_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   LEN_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] CNT_LAST = AW'(DEPTH - 1);

    state_t        r_state;
    state_t        w_next;
    logic [AW-1:0] r_cnt;
    logic [AW:0]   r_len;
    logic [7:0]    r_csum;

    logic          w_xfer;
    logic          w_len_ok;
    logic          w_data_last;
    logic          w_we;
    logic [DW-1:0] w_wdata;

    assign w_xfer      = ld_valid_i & ld_ready_o;
    assign w_len_ok    = (ld_data_i != 8'd0) && (ld_data_i <= 8'(DEPTH));
    assign w_data_last = ({1'b0, r_cnt} == (r_len - LEN_ONE));

    // Payload bytes land at cnt during DATA; FILL zeroes the tail; an abort cycle writes nothing
    assign w_we    = ~ld_start_i & (((r_state == ST_DATA) & w_xfer) | (r_state == ST_FILL));
    assign w_wdata = (r_state == ST_DATA) ? DW'(ld_data_i) : '0;

    prog_mem #(
        .AW    (AW),
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (w_we),
        .waddr_i (r_cnt),
        .wdata_i (w_wdata),
        .raddr_i (p_addr_i),
        .rdata_o (p_data_o)
    );

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state: a start pulse from any state (re)opens a load at LEN
    always_comb begin
        w_next = r_state;
        if (ld_start_i) begin
            w_next = ST_LEN;
        end else begin
            case (r_state)
                ST_LEN: begin
                    if (w_xfer) w_next = w_len_ok ? ST_DATA : ST_ERR;
                end
                ST_DATA: begin
                    if (w_xfer && w_data_last) w_next = (r_len == LEN_FULL) ? ST_CSUM : ST_FILL;
                end
                ST_FILL: begin
                    if (r_cnt == CNT_LAST) w_next = ST_CSUM;
                end
                ST_CSUM: begin
                    if (w_xfer) w_next = (ld_data_i == r_csum) ? ST_RUN : ST_ERR;
                end
                default: w_next = r_state;
            endcase
        end
    end

    // Outputs decoded from state; start masks ready so it pre-empts a same-cycle byte
    always_comb begin
        ld_ready_o = 1'b0;
        busy_o     = 1'b0;
        err_o      = 1'b0;
        cpu_rst_o  = 1'b1;
        case (r_state)
            ST_LEN, ST_DATA, ST_CSUM: begin
                ld_ready_o = ~ld_start_i;
                busy_o     = 1'b1;
            end
            ST_FILL: busy_o    = 1'b1;
            ST_RUN:  cpu_rst_o = 1'b0;
            ST_ERR:  err_o     = 1'b1;
            default: ;
        endcase
    end

    // Write pointer, program length and running checksum
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt  <= '0;
            r_len  <= '0;
            r_csum <= '0;
        end else if (ld_start_i) begin
            r_cnt  <= '0;
            r_csum <= '0;
        end else begin
            case (r_state)
                ST_LEN: begin
                    if (w_xfer && w_len_ok) begin
                        r_len  <= ld_data_i[AW:0];
                        r_cnt  <= '0;
                        r_csum <= '0;
                    end
                end
                ST_DATA: begin
                    if (w_xfer) begin
                        r_csum <= r_csum ^ ld_data_i;
                        r_cnt  <= r_cnt + AW'(1);
                    end
                end
                ST_FILL: r_cnt <= r_cnt + AW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - randomized scoreboard bench for prog_loader
module tb_prog_loader;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [3:0] p_addr_i;
    logic [7:0] p_data_o;
    logic       cpu_rst_o;
    logic       ld_start_i;
    logic [7:0] ld_data_i;
    logic       ld_valid_i;
    logic       ld_ready_o;
    logic       busy_o;
    logic       err_o;

    prog_loader dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .p_addr_i   (p_addr_i),
        .p_data_o   (p_data_o),
        .cpu_rst_o  (cpu_rst_o),
        .ld_start_i (ld_start_i),
        .ld_data_i  (ld_data_i),
        .ld_valid_i (ld_valid_i),
        .ld_ready_o (ld_ready_o),
        .busy_o     (busy_o),
        .err_o      (err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic            err;
        logic            cpu_rst;
        logic [15:0][7:0] mem;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] ref_mem [16];
    logic [7:0] pay[$];
    int         total = 0;
    int         bad = 0;
    int         chk_req = 0;
    int         done_cnt = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endfunction

    function automatic exp_t snap(input logic e, input logic cr);
        exp_t x;
        x.err = e;
        x.cpu_rst = cr;
        for (int i = 0; i < 16; i++) x.mem[i] = ref_mem[i];
        return x;
    endfunction

    // Monitor: whenever a load concludes (busy falls) or a check is requested, pop and compare
    initial begin
        bit   pb = 1'b0;
        int   seen = 0;
        exp_t e;
        p_addr_i = 4'd0;
        forever begin
            @(negedge clk_i);
            if ((pb && !busy_o) || (chk_req != seen)) begin
                seen = chk_req;
                if (sb.size() == 0) begin
                    chk("sb_empty", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("err_o", {31'd0, err_o}, {31'd0, e.err});
                    chk("cpu_rst_o", {31'd0, cpu_rst_o}, {31'd0, e.cpu_rst});
                    for (int a = 0; a < 16; a++) begin
                        p_addr_i = 4'(a);
                        #1;
                        chk($sformatf("mem[%0d]", a), {24'd0, p_data_o}, {24'd0, e.mem[a]});
                    end
                end
                done_cnt++;
            end
            pb = busy_o;
        end
    end

    task automatic wait_checked(input int target);
        int n = 0;
        while (done_cnt < target && n < 300) begin
            @(posedge clk_i);
            n++;
        end
        if (done_cnt < target) chk("check_timeout", 32'd1, 32'd0);
        @(posedge clk_i);
        #1;
    endtask

    task automatic start_pulse();
        ld_start_i = 1'b1;
        ld_valid_i = 1'b1;
        ld_data_i  = 8'($urandom);
        @(negedge clk_i);
        chk("ready_during_start", {31'd0, ld_ready_o}, 32'd0);
        @(posedge clk_i);
        #1;
        ld_start_i = 1'b0;
        ld_valid_i = 1'b0;
        @(negedge clk_i);
        chk("busy_after_start", {31'd0, busy_o}, 32'd1);
        chk("err_after_start", {31'd0, err_o}, 32'd0);
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit jitter);
        bit xf = 1'b0;
        int n = 0;
        while (!xf && n < 60) begin
            ld_valid_i = jitter ? 1'($urandom_range(0, 1)) : 1'b1;
            ld_data_i  = ld_valid_i ? b : 8'($urandom);
            @(negedge clk_i);
            xf = ld_valid_i & ld_ready_o;
            @(posedge clk_i);
            #1;
            n++;
        end
        ld_valid_i = 1'b0;
        if (!xf) chk("send_timeout", 32'd1, 32'd0);
    endtask

    // cs_ovr < 0 sends the correct checksum, otherwise sends cs_ovr as given
    task automatic do_load(input logic [7:0] lb, input int cs_ovr, input bit jitter);
        int         len = int'(lb);
        int         tgt = done_cnt + 1;
        int         fc = 0;
        logic [7:0] x = 8'd0;
        logic [7:0] cs;
        bit         good;
        start_pulse();
        if (len == 0 || len > 16) begin
            sb.push_back(snap(1'b1, 1'b1));
            send_byte(lb, jitter);
        end else begin
            for (int i = 0; i < 16; i++) ref_mem[i] = (i < len) ? pay[i] : 8'd0;
            for (int i = 0; i < len; i++) x = x ^ pay[i];
            cs = (cs_ovr < 0) ? x : 8'(cs_ovr);
            good = (cs == x);
            sb.push_back(snap(!good, !good));
            send_byte(lb, jitter);
            for (int i = 0; i < len; i++) send_byte(pay[i], jitter);
            while (fc < 40) begin
                @(negedge clk_i);
                if (ld_ready_o) break;
                fc++;
            end
            chk("fill_cycles", 32'(fc), 32'(16 - len));
            @(posedge clk_i);
            #1;
            send_byte(cs, jitter);
            @(negedge clk_i);
            chk("cpu_rst_after_csum", {31'd0, cpu_rst_o}, {31'd0, !good});
        end
        wait_checked(tgt);
    endtask

    initial begin
        rst_i      = 1'b1;
        ld_start_i = 1'b0;
        ld_valid_i = 1'b0;
        ld_data_i  = 8'd0;
        for (int i = 0; i < 16; i++) ref_mem[i] = 8'd0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        chk("busy_reset", {31'd0, busy_o}, 32'd0);
        sb.push_back(snap(1'b0, 1'b1));
        chk_req++;
        wait_checked(done_cnt + 1);

        pay = '{8'hA1, 8'hB2, 8'hC3};
        do_load(8'h03, -1, 1'b0);

        pay.delete();
        for (int i = 0; i < 16; i++) pay.push_back(8'(i));
        do_load(8'h10, -1, 1'b0);

        pay = '{8'h11, 8'h22};
        do_load(8'h02, 0, 1'b0);

        do_load(8'h00, -1, 1'b0);
        do_load(8'h11, -1, 1'b0);

        // Aborted load leaves its accepted bytes; a following bad-length load exposes them
        start_pulse();
        send_byte(8'h05, 1'b1);
        for (int i = 0; i < 3; i++) begin
            ref_mem[i] = 8'($urandom);
            send_byte(ref_mem[i], 1'b1);
        end
        do_load(8'h00, -1, 1'b1);

        for (int t = 0; t < 20; t++) begin
            int L;
            pay.delete();
            if ($urandom_range(0, 9) == 0) begin
                L = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(17, 255);
            end else begin
                L = $urandom_range(1, 16);
                for (int i = 0; i < L; i++) pay.push_back(8'($urandom));
            end
            do_load(8'(L), ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : -1, 1'b1);
        end

        pay = '{8'h5A, 8'hC3, 8'h01, 8'h77};
        do_load(8'h04, -1, 1'b1);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        for (int i = 0; i < 16; i++) ref_mem[i] = 8'd0;
        chk("busy_after_rst", {31'd0, busy_o}, 32'd0);
        sb.push_back(snap(1'b0, 1'b1));
        chk_req++;
        wait_checked(done_cnt + 1);

        chk("sb_leftover", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
